udp_tx_mux: RTL and testbench
=============================

# udp_tx_mux

Parametrised N-channel transmit front end for the UDP engine. It arbitrates packet requests from several producers, such as radar frame streamers or debug taps. It latches the winning channel's lengths, issues the single-cycle `tx_start`, and routes the engine's word requests and data between the engine and the granted channel. It counts payload words to detect the end of each packet and enforces an inter-packet gap. It sits between the signal-processing producers and the `udp` core inside the Ethernet top level, in the `e_rxc` domain.

## Interface
- `NCH`, 4: number of producer channels, 2..16.
- `DW`, 32: payload word width in bits, multiple of 8.
- `GAP_CYC`, 12: idle cycles after a packet before the next grant, ≥1.
- `e_rxc` in 1: 125 MHz GMII clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `ch_req` in NCH: level request; channel holds it and its lengths stable until its `ch_grant` bit rises.
- `ch_total_length` in NCH*16: IP total length per channel, packed with channel 0 at LSBs.
- `ch_data_length` in NCH*16: UDP length per channel (payload + 8), packed.
- `ch_data` in NCH*DW: payload word per channel, packed.
- `ch_grant` out NCH: one-hot, high from START through the last STREAM cycle.
- `ch_data_req` out NCH: `tx_data_req` routed to the granted bit; all other bits 0.
- `ch_done` out NCH: one-cycle pulse when a channel's packet completes or is rejected.
- `ch_err` out NCH: one-cycle pulse, coincident with `ch_done`, on length rejection.
- `tx_start` out 1: one-cycle start pulse to the engine.
- `tx_total_length`, `tx_data_length` out 16: latched lengths, stable from START until the next grant.
- `tx_data` out DW: combinational mux of `ch_data[grant]`; 0 when no grant.
- `tx_data_req` in 1: word request from the engine.
- `active_ch` out $clog2(NCH): index of the granted or last-granted channel.

## Operation
- States: IDLE, CHECK, START, STREAM, GAP.
- **IDLE:** if any `ch_req` is set, pick a winner round-robin starting at `last+1` mod NCH. Latch its lengths, `active_ch` and `last`, then go to CHECK. `ch_req` is sampled only in IDLE.
- **CHECK**, one cycle, validates the latched lengths:
  - Reject if `data_length < 8` or `total_length != data_length + 20`.
  - On reject: pulse `ch_done` and `ch_err`, no `tx_start`, go to GAP.
  - Otherwise compute `words = ceil((data_length-8) / (DW/8))` into a 14-bit counter, assert `ch_grant`, and go to START.
- **START:** `tx_start`=1 for exactly one cycle. If `words==0`, pulse `ch_done`, drop grant and go to GAP; else go to STREAM.
- **STREAM:** each cycle with `tx_data_req`=1 decrements the counter. When it reaches 0 on that edge, pulse `ch_done` next cycle, drop `ch_grant`, and go to GAP.
- **GAP:** count `GAP_CYC` cycles, then go to IDLE.
- `tx_data_req` outside STREAM is ignored: no `ch_data_req`, no count.
- A channel still holding `ch_req` after its `ch_done` is treated as a new packet and competes normally.
- Reset or reset mid-packet: state IDLE, `last`=NCH-1 (channel 0 wins first), counters 0.
  - All outputs reset to 0: `ch_grant`, `ch_data_req`, `ch_done`, `ch_err`, `tx_start`, both lengths, `active_ch`.
  - The engine is not notified of an abandoned packet.

## Timing
- Request to `tx_start` latency: 3 cycles (IDLE sample → CHECK → START) when idle.
- `ch_data_req` and `tx_data` are combinational from `tx_data_req` / `ch_data`, with zero latency. The producer presents the word in the same cycle it sees `ch_data_req`.
- Minimum spacing between consecutive `tx_start` pulses: `words + GAP_CYC + 3` cycles.
- `ch_done` is registered, one cycle after the last counted request.

## Configuration
- `UDP_TX_MUX_PRIO_EN` defined: channel 0 has strict priority. If `ch_req[0]` is set in IDLE it wins; channels 1..NCH-1 are round-robin among themselves.
- Undefined: pure round-robin over all NCH channels.

## Structure
- Package `udp_pkg`:
  - state enum `udp_mux_state_t`;
  - constants `UDP_HDR_BYTES`=8, `IP_HDR_BYTES`=20, `LEN_W`=16.
- Sub-module `rr_arbiter` (parameter NCH): request vector + `last` pointer + priority-enable input → one-hot grant and index. Purely combinational, reused by the RX demux.

## Test plan
- **Single packet:** NCH=4, DW=32, ch2 requests `data_length`=28, `total_length`=48. Expect `tx_start` 3 cycles later, exactly 5 `ch_data_req[2]` pulses, `ch_done[2]`, then 12 idle cycles.
- **Round-robin:** ch0, ch1 and ch3 all request continuously. Expect grant order 0,1,3,0,1,3, each packet separated by ≥ `GAP_CYC`.
- **Rejection:** ch1 requests `data_length`=30, `total_length`=49. Expect `ch_err[1]` and `ch_done[1]`, no `tx_start`, then GAP.
- **Boundaries:**
  - `data_length`=8: `tx_start` then `ch_done` with zero `ch_data_req`.
  - `data_length`=9: exactly 1 word.
- **Reset mid-STREAM:** assert `reset` after 2 of 10 words. Next cycle all outputs are 0; after release, ch0 wins the first arbitration.
- **Priority:** with `UDP_TX_MUX_PRIO_EN`, ch0 re-requesting every packet beats pending ch1 every time. Without the macro, ch1 is served after each ch0 packet.

Source files
------------

// File: rtl/udp_pkg.sv
// udp_pkg: shared types and constants for the UDP transmit/receive muxing logic.
//   udp_mux_state_t : transmit mux FSM state encoding
//   UDP_HDR_BYTES   : UDP header size in bytes
//   IP_HDR_BYTES    : IPv4 header size in bytes (no options)
//   LEN_W           : width of the IP/UDP length fields
//   WCNT_W          : width of the payload word counter
package udp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_START  = 3'd2,
    ST_STREAM = 3'd3,
    ST_GAP    = 3'd4
  } udp_mux_state_t;

  localparam int UDP_HDR_BYTES = 8;
  localparam int IP_HDR_BYTES  = 20;
  localparam int LEN_W         = 16;
  localparam int WCNT_W        = 14;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter with optional strict priority
// for channel 0. The search starts at last+1 (mod NCH).
//   req     in  NCH : request vector
//   last    in  IW  : index of the previously granted channel
//   prio_en in  1   : channel 0 wins whenever it requests; the others rotate
//   grant   out NCH : one-hot grant, all zero when nothing requests
//   idx     out IW  : index of the granted channel (0 when no grant)
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  input  logic           prio_en,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  idx
);

  logic [IW-1:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    c     = '0;
    if (prio_en && req[0]) begin
      grant[0] = 1'b1;
    end else begin
      for (int i = 1; i <= NCH; i++) begin
        c = IW'((int'(last) + i) % NCH);
        // In priority mode channel 0 is handled above, so the rotation skips it.
        if ((grant == '0) && req[c] && !(prio_en && (c == '0))) begin
          grant[c] = 1'b1;
          idx      = c;
        end
      end
    end
  end

endmodule

// File: rtl/udp_tx_mux.sv
// udp_tx_mux: N-channel transmit front end for the UDP engine.
// Arbitrates producer requests, validates and latches the winner's lengths,
// issues tx_start, routes word requests/data and enforces an inter-packet gap.
// Optional build macro UDP_TX_MUX_PRIO_EN gives channel 0 strict priority.
//   e_rxc, reset        : clock and synchronous active-high reset
//   ch_req              : per-channel level request
//   ch_total_length     : packed per-channel IP total length (ch0 at LSBs)
//   ch_data_length      : packed per-channel UDP length
//   ch_data             : packed per-channel payload word
//   ch_grant            : one-hot grant, START through last STREAM cycle
//   ch_data_req         : tx_data_req routed to the granted channel
//   ch_done, ch_err     : completion / rejection pulses
//   tx_start            : one-cycle start pulse to the engine
//   tx_total_length,
//   tx_data_length      : latched lengths of the current packet
//   tx_data             : payload word of the granted channel
//   tx_data_req         : word request from the engine
//   active_ch           : granted or last-granted channel index
//
// state  | meaning
// IDLE   | arbitrate, latch winner's lengths
// CHECK  | validate lengths, load word counter
// START  | tx_start pulse
// STREAM | count engine word requests down to zero
// GAP    | inter-packet idle time
module udp_tx_mux
  import udp_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = 32,
  parameter int GAP_CYC = 12
) (
  input  logic                     e_rxc,
  input  logic                     reset,
  input  logic [NCH-1:0]           ch_req,
  input  logic [NCH*LEN_W-1:0]     ch_total_length,
  input  logic [NCH*LEN_W-1:0]     ch_data_length,
  input  logic [NCH*DW-1:0]        ch_data,
  output logic [NCH-1:0]           ch_grant,
  output logic [NCH-1:0]           ch_data_req,
  output logic [NCH-1:0]           ch_done,
  output logic [NCH-1:0]           ch_err,
  output logic                     tx_start,
  output logic [LEN_W-1:0]         tx_total_length,
  output logic [LEN_W-1:0]         tx_data_length,
  output logic [DW-1:0]            tx_data,
  input  logic                     tx_data_req,
  output logic [$clog2(NCH)-1:0]   active_ch
);

  localparam int IW  = $clog2(NCH);
  localparam int BPW = DW / 8;
  localparam int GW  = $clog2(GAP_CYC + 1);

`ifdef UDP_TX_MUX_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  udp_mux_state_t state, state_nxt;

  logic [IW-1:0]     last_q;
  logic [WCNT_W-1:0] word_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [NCH-1:0]    arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;
  logic [LEN_W-1:0]  sel_tot, sel_dat;
  logic [LEN_W:0]    payload_bytes;
  logic [WCNT_W-1:0] words_calc;
  logic              len_ok;
  logic [NCH-1:0]    act_onehot;
  logic              prio_en;

  assign prio_en = PRIO_EN;

  rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .req     (ch_req),
    .last    (last_q),
    .prio_en (prio_en),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  assign arb_valid = |arb_grant;
  assign sel_tot   = ch_total_length[arb_idx*LEN_W +: LEN_W];
  assign sel_dat   = ch_data_length[arb_idx*LEN_W +: LEN_W];

  // Compare in LEN_W+1 bits so data_length+20 cannot wrap into a false match.
  assign len_ok = (tx_data_length >= LEN_W'(UDP_HDR_BYTES)) &&
                  ({1'b0, tx_total_length} ==
                   ({1'b0, tx_data_length} + (LEN_W+1)'(IP_HDR_BYTES)));

  assign payload_bytes = {1'b0, tx_data_length} - (LEN_W+1)'(UDP_HDR_BYTES);
  assign words_calc    = WCNT_W'((payload_bytes + (LEN_W+1)'(BPW - 1)) / (LEN_W+1)'(BPW));

  assign act_onehot = NCH'(1) << active_ch;

  always_ff @(posedge e_rxc) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (arb_valid) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = len_ok ? ST_START : ST_GAP;
      ST_START:  state_nxt = (word_cnt == '0) ? ST_GAP : ST_STREAM;
      ST_STREAM: if (tx_data_req && (word_cnt == WCNT_W'(1))) state_nxt = ST_GAP;
      ST_GAP:    if (gap_cnt == '0) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge e_rxc) begin
    if (reset) begin
      last_q          <= IW'(NCH - 1);
      active_ch       <= '0;
      tx_total_length <= '0;
      tx_data_length  <= '0;
      word_cnt        <= '0;
      gap_cnt         <= '0;
      ch_grant        <= '0;
      ch_done         <= '0;
      ch_err          <= '0;
      tx_start        <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      ch_done  <= '0;
      ch_err   <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            active_ch       <= arb_idx;
            last_q          <= arb_idx;
            tx_total_length <= sel_tot;
            tx_data_length  <= sel_dat;
          end
        end
        ST_CHECK: begin
          if (len_ok) begin
            word_cnt <= words_calc;
            ch_grant <= act_onehot;
            tx_start <= 1'b1;
          end else begin
            ch_done <= act_onehot;
            ch_err  <= act_onehot;
            gap_cnt <= GW'(GAP_CYC - 1);
          end
        end
        ST_START: begin
          if (word_cnt == '0) begin
            ch_done  <= ch_grant;
            ch_grant <= '0;
            gap_cnt  <= GW'(GAP_CYC - 1);
          end
        end
        ST_STREAM: begin
          if (tx_data_req) begin
            word_cnt <= word_cnt - WCNT_W'(1);
            if (word_cnt == WCNT_W'(1)) begin
              ch_done  <= ch_grant;
              ch_grant <= '0;
              gap_cnt  <= GW'(GAP_CYC - 1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
        end
        default: ;
      endcase
    end
  end

  // Engine requests outside STREAM never reach a producer.
  assign ch_data_req = ((state == ST_STREAM) && tx_data_req) ? ch_grant : '0;

  always_comb begin
    tx_data = '0;
    if (|ch_grant) tx_data = ch_data[active_ch*DW +: DW];
  end

endmodule

// File: tb/tb_udp_tx_mux.sv
module tb_udp_tx_mux;
  localparam int NCH     = 4;
  localparam int DW      = 32;
  localparam int GAP_CYC = 12;

  logic              e_rxc = 1'b0;
  logic              reset;
  logic [NCH-1:0]    ch_req;
  logic [NCH*16-1:0] ch_total_length;
  logic [NCH*16-1:0] ch_data_length;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_grant, ch_data_req, ch_done, ch_err;
  logic              tx_start;
  logic [15:0]       tx_total_length, tx_data_length;
  logic [DW-1:0]     tx_data;
  logic              tx_data_req;
  logic [1:0]        active_ch;

  int checks = 0;
  int errors = 0;

  udp_tx_mux #(.NCH(NCH), .DW(DW), .GAP_CYC(GAP_CYC)) dut (
    .e_rxc           (e_rxc),
    .reset           (reset),
    .ch_req          (ch_req),
    .ch_total_length (ch_total_length),
    .ch_data_length  (ch_data_length),
    .ch_data         (ch_data),
    .ch_grant        (ch_grant),
    .ch_data_req     (ch_data_req),
    .ch_done         (ch_done),
    .ch_err          (ch_err),
    .tx_start        (tx_start),
    .tx_total_length (tx_total_length),
    .tx_data_length  (tx_data_length),
    .tx_data         (tx_data),
    .tx_data_req     (tx_data_req),
    .active_ch       (active_ch)
  );

  always #4 e_rxc = ~e_rxc;

  function automatic logic [DW-1:0] pat(input int c);
    return 32'hDA7A_0000 + 32'(c);
  endfunction

  task automatic set_len(input int c, input int dl, input int tl);
    ch_data_length[c*16 +: 16]  = 16'(dl);
    ch_total_length[c*16 +: 16] = 16'(tl);
  endtask

  task automatic wait_idle();
    repeat (GAP_CYC + 6) @(posedge e_rxc);
    #2;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge e_rxc);
    #2;
    reset = 1'b0;
  endtask

  // Requests one packet on channel c and follows it until ch_done[c] (bounded).
  // Cycle 1 is the first cycle after the edge that samples the request.
  task automatic run_pkt(input int c, input int dl, input int tl, input bit stall,
                         output int t_start, output int n_start, output int n_dreq,
                         output int t_done, output bit err, output int bad);
    set_len(c, dl, tl);
    ch_req[c] = 1'b1;
    t_start = -1; n_start = 0; n_dreq = 0; t_done = -1; err = 0; bad = 0;
    for (int cyc = 1; cyc <= 100 && t_done < 0; cyc++) begin
      @(posedge e_rxc);
      #1;
      tx_data_req = stall ? cyc[0] : 1'b1;
      #1;
      if (tx_start) begin
        n_start++;
        if (t_start < 0) t_start = cyc;
      end
      if (ch_data_req != '0) begin
        if (ch_data_req == (4'(1) << c)) n_dreq++;
        else bad++;
        if (tx_data !== pat(c)) bad++;
      end
      if (ch_err != '0 && ch_done == '0) bad++;
      if (ch_done[c]) begin
        t_done = cyc;
        err    = ch_err[c];
      end
      if (ch_grant[c] || ch_done[c]) ch_req[c] = 1'b0;
    end
    tx_data_req = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge e_rxc);
    #2;
    checks++;
    if ({ch_grant, ch_data_req, ch_done, ch_err, tx_start, active_ch} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h required 0",
               {ch_grant, ch_data_req, ch_done, ch_err, tx_start, active_ch});
    end
    checks++;
    if ({tx_total_length, tx_data_length, tx_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0", {tx_total_length, tx_data_length, tx_data});
    end
    reset = 1'b0;
  endtask

  task automatic test_single_packet();
    int ts, ns, nd, td, bad;
    bit er;
    run_pkt(2, 28, 48, 1'b0, ts, ns, nd, td, er, bad);
    checks++; if (ts !== 2) begin errors++; $display("FAIL single_t_start: got %0d required 2", ts); end
    checks++; if (ns !== 1) begin errors++; $display("FAIL single_n_start: got %0d required 1", ns); end
    checks++; if (nd !== 5) begin errors++; $display("FAIL single_words: got %0d required 5", nd); end
    checks++; if (td !== 8) begin errors++; $display("FAIL single_t_done: got %0d required 8", td); end
    checks++; if (er !== 1'b0 || bad !== 0) begin errors++; $display("FAIL single_err_bad: got err=%0d bad=%0d required 0 0", er, bad); end
    checks++;
    if (tx_total_length !== 16'd48 || tx_data_length !== 16'd28 || active_ch !== 2'd2) begin
      errors++;
      $display("FAIL single_latched: got %0d %0d ch%0d required 48 28 ch2",
               tx_total_length, tx_data_length, active_ch);
    end
    // Boundary data_length=8, requested the moment ch2 completes: gap then zero words.
    run_pkt(0, 8, 28, 1'b0, ts, ns, nd, td, er, bad);
    checks++; if (ts !== GAP_CYC + 2) begin errors++; $display("FAIL gap_t_start: got %0d required %0d", ts, GAP_CYC + 2); end
    checks++; if (nd !== 0 || bad !== 0) begin errors++; $display("FAIL zero_words: got %0d bad=%0d required 0 0", nd, bad); end
    checks++; if (td !== GAP_CYC + 3 || er !== 1'b0) begin errors++; $display("FAIL zero_t_done: got %0d err=%0d required %0d 0", td, er, GAP_CYC + 3); end
    wait_idle();
  endtask

  task automatic test_reject();
    int ts, ns, nd, td, bad;
    bit er;
    run_pkt(1, 30, 49, 1'b0, ts, ns, nd, td, er, bad);
    checks++; if (td !== 2 || er !== 1'b1) begin errors++; $display("FAIL rej_done: got t=%0d err=%0d required 2 1", td, er); end
    checks++; if (ns !== 0 || nd !== 0) begin errors++; $display("FAIL rej_quiet: got start=%0d dreq=%0d required 0 0", ns, nd); end
    // Boundary data_length=9: one word, after the full gap.
    run_pkt(1, 9, 29, 1'b0, ts, ns, nd, td, er, bad);
    checks++; if (ts !== GAP_CYC + 2) begin errors++; $display("FAIL rej_gap: got %0d required %0d", ts, GAP_CYC + 2); end
    checks++; if (nd !== 1 || bad !== 0) begin errors++; $display("FAIL one_word: got %0d bad=%0d required 1 0", nd, bad); end
    checks++; if (td !== GAP_CYC + 4 || er !== 1'b0) begin errors++; $display("FAIL one_t_done: got %0d err=%0d required %0d 0", td, er, GAP_CYC + 4); end
    wait_idle();
    run_pkt(3, 4, 24, 1'b0, ts, ns, nd, td, er, bad);
    checks++; if (td !== 2 || er !== 1'b1 || ns !== 0) begin errors++; $display("FAIL rej_short: got t=%0d err=%0d start=%0d required 2 1 0", td, er, ns); end
    wait_idle();
  endtask

  task automatic test_stall();
    int ts, ns, nd, td, bad;
    bit er;
    run_pkt(3, 20, 40, 1'b1, ts, ns, nd, td, er, bad);
    checks++; if (nd !== 3 || bad !== 0) begin errors++; $display("FAIL stall_words: got %0d bad=%0d required 3 0", nd, bad); end
    checks++; if (td !== 8) begin errors++; $display("FAIL stall_t_done: got %0d required 8", td); end
    wait_idle();
  endtask

  // Holds the request vector and records channel/cycle of the first n tx_start pulses.
  task automatic collect_starts(input logic [NCH-1:0] reqs, input int n,
                                output int st_cyc[8], output int st_ch[8], output int nst);
    nst = 0;
    for (int k = 0; k < 8; k++) begin st_cyc[k] = -1; st_ch[k] = -1; end
    ch_req = reqs;
    tx_data_req = 1'b1;
    for (int cyc = 1; cyc <= 300 && nst < n; cyc++) begin
      @(posedge e_rxc);
      #2;
      if (tx_start) begin
        st_cyc[nst] = cyc;
        st_ch[nst]  = int'(active_ch);
        nst++;
      end
    end
    ch_req = '0;
  endtask

  task automatic test_round_robin();
    int st_cyc[8], st_ch[8], nst;
    int exp_ch[6];
    apply_reset();
    set_len(0, 16, 36); set_len(1, 16, 36); set_len(3, 16, 36);
`ifdef UDP_TX_MUX_PRIO_EN
    exp_ch = '{0, 0, 0, 0, 0, 0};
`else
    exp_ch = '{0, 1, 3, 0, 1, 3};
`endif
    collect_starts(4'b1011, 6, st_cyc, st_ch, nst);
    checks++; if (nst !== 6) begin errors++; $display("FAIL rr_count: got %0d required 6", nst); end
    checks++; if (st_cyc[0] !== 2) begin errors++; $display("FAIL rr_first: got %0d required 2", st_cyc[0]); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (st_ch[k] !== exp_ch[k]) begin errors++; $display("FAIL rr_order[%0d]: got ch%0d required ch%0d", k, st_ch[k], exp_ch[k]); end
    end
    for (int k = 1; k < 6; k++) begin
      checks++;
      if (st_cyc[k] - st_cyc[k-1] !== 2 + GAP_CYC + 3) begin
        errors++;
        $display("FAIL rr_spacing[%0d]: got %0d required %0d", k, st_cyc[k] - st_cyc[k-1], 2 + GAP_CYC + 3);
      end
    end
    wait_idle();
  endtask

  task automatic test_priority();
    int st_cyc[8], st_ch[8], nst;
    int exp_ch[4];
    apply_reset();
    set_len(0, 8, 28); set_len(1, 8, 28);
`ifdef UDP_TX_MUX_PRIO_EN
    exp_ch = '{0, 0, 0, 0};
`else
    exp_ch = '{0, 1, 0, 1};
`endif
    collect_starts(4'b0011, 4, st_cyc, st_ch, nst);
    checks++; if (nst !== 4) begin errors++; $display("FAIL prio_count: got %0d required 4", nst); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (st_ch[k] !== exp_ch[k]) begin errors++; $display("FAIL prio_order[%0d]: got ch%0d required ch%0d", k, st_ch[k], exp_ch[k]); end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int nd, ts;
    nd = 0;
    set_len(2, 48, 68);
    ch_req[2] = 1'b1;
    tx_data_req = 1'b1;
    for (int cyc = 1; cyc <= 50 && nd < 2; cyc++) begin
      @(posedge e_rxc);
      #2;
      if (ch_data_req[2]) nd++;
      if (ch_grant[2]) ch_req[2] = 1'b0;
    end
    checks++; if (nd !== 2) begin errors++; $display("FAIL mid_progress: got %0d required 2", nd); end
    reset = 1'b1;
    @(posedge e_rxc);
    #2;
    checks++;
    if ({ch_grant, ch_data_req, ch_done, ch_err, tx_start, active_ch} !== '0) begin
      errors++;
      $display("FAIL mid_reset_ctrl: got %h required 0",
               {ch_grant, ch_data_req, ch_done, ch_err, tx_start, active_ch});
    end
    checks++;
    if ({tx_total_length, tx_data_length, tx_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset_data: got %h required 0", {tx_total_length, tx_data_length, tx_data});
    end
    reset = 1'b0;
    set_len(0, 8, 28); set_len(3, 8, 28);
    ch_req = 4'b1001;
    ts = -1;
    for (int cyc = 1; cyc <= 20 && ts < 0; cyc++) begin
      @(posedge e_rxc);
      #2;
      if (tx_start) ts = cyc;
    end
    ch_req = '0;
    checks++; if (ts !== 2) begin errors++; $display("FAIL mid_restart_t: got %0d required 2", ts); end
    checks++; if (active_ch !== 2'd0) begin errors++; $display("FAIL mid_first_winner: got ch%0d required ch0", active_ch); end
    wait_idle();
  endtask

  initial begin
    reset           = 1'b1;
    ch_req          = '0;
    ch_total_length = '0;
    ch_data_length  = '0;
    tx_data_req     = 1'b0;
    for (int c = 0; c < NCH; c++) ch_data[c*DW +: DW] = pat(c);
    test_reset();
    test_single_packet();
    test_reject();
    test_stall();
    test_round_robin();
    test_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
